// File: rtl/signed_or_unsigned_div.sv
// Sequential restoring divider, signed or unsigned per operation, one quotient bit per cycle.
// Optional build macro SIGNED_OR_UNSIGNED_DIV_EARLY_EXIT_EN skips iteration when the result is trivial.
module signed_or_unsigned_div #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arg_vld,
  output logic         arg_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         signed_div,
  output logic         res_vld,
  output logic [n-1:0] quot,
  output logic [n-1:0] rem,
  output logic         div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [n-1:0] LAST = n'(n - 1);

  logic [1:0]   state;
  logic [n-1:0] cnt;
  logic [n:0]   prem;
  logic [n-1:0] qacc;
  logic [n-1:0] dvs;
  logic [n-1:0] dvd_raw;
  logic         neg_q;
  logic         neg_r;
  logic         bz;

  logic [n-1:0] abs_a;
  logic [n-1:0] abs_b;
  logic [n:0]   diff;
  logic         fits;
  logic [n-1:0] rnow;
  logic         accept;

  // prem holds the partial remainder already shifted left with the next dividend bit
  always_comb begin
    abs_a = (signed_div && a[n-1]) ? (~a + 1'b1) : a;
    abs_b = (signed_div && b[n-1]) ? (~b + 1'b1) : b;
    diff  = prem - {1'b0, dvs};
    fits  = ~diff[n];
    rnow  = fits ? diff[n-1:0] : prem[n-1:0];
  end

  assign arg_rdy = (state == IDLE);
  assign accept  = arg_vld & arg_rdy;

`ifdef SIGNED_OR_UNSIGNED_DIV_EARLY_EXIT_EN
  logic early;
  assign early = (b == '0) || (abs_a < abs_b);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      res_vld     <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dvs     <= abs_b;
            prem    <= {{n{1'b0}}, abs_a[n-1]};
            qacc    <= {abs_a[n-2:0], 1'b0};
            dvd_raw <= a;
            bz      <= (b == '0);
            neg_q   <= signed_div & (a[n-1] ^ b[n-1]);
            neg_r   <= signed_div & a[n-1];
            cnt     <= '0;
`ifdef SIGNED_OR_UNSIGNED_DIV_EARLY_EXIT_EN
            if (early) begin
              state       <= DONE;
              res_vld     <= 1'b1;
              quot        <= (b == '0) ? {n{1'b1}} : {n{1'b0}};
              rem         <= a;
              div_by_zero <= (b == '0);
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          prem <= {rnow, qacc[n-1]};
          qacc <= {qacc[n-2:0], fits};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          state       <= DONE;
          res_vld     <= 1'b1;
          div_by_zero <= bz;
          // divide by zero reports all-ones and the untouched dividend regardless of signs
          if (bz) begin
            quot <= {n{1'b1}};
            rem  <= dvd_raw;
          end else begin
            quot <= neg_q ? (~qacc + 1'b1) : qacc;
            rem  <= neg_r ? (~prem[n:1] + 1'b1) : prem[n:1];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
